// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter.
// A single-cycle ALU result and a queue of long-latency LSU results share one
// register-file write port. The ALU always wins; LSU results wait in a small
// FIFO and drain whenever the ALU is idle. A per-register scoreboard tracks
// destinations of issued long-latency ops until their result is written.
//
// Handshakes:
//   ALU : alu_valid & (alu_reg != 0) is a write this cycle. No backpressure.
//         alu_reg == 0 is a no-op.
//   LSU : a result transfers on a rising edge where lsu_valid & lsu_ready.
//         lsu_ready depends only on the registered FIFO occupancy, never on a
//         same-cycle pop, so it has no combinational path from the inputs.
//         A transfer with lsu_reg == 0 is consumed but never queued.
module reg_write_arbiter #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 5,
  parameter int DEPTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [ADDRESS_SIZE-1:0]      alu_reg,
  input  logic [WORD_SIZE-1:0]         alu_data,
  input  logic                         lsu_valid,
  output logic                         lsu_ready,
  input  logic [ADDRESS_SIZE-1:0]      lsu_reg,
  input  logic [WORD_SIZE-1:0]         lsu_data,
  input  logic                         issue_valid,
  input  logic [ADDRESS_SIZE-1:0]      issue_reg,
  input  logic [ADDRESS_SIZE-1:0]      query_reg,
  output logic                         query_pending,
  output logic [(1<<ADDRESS_SIZE)-1:0] pending,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         RegWrite,
  output logic [ADDRESS_SIZE-1:0]      WriteReg,
  output logic [WORD_SIZE-1:0]         WriteData
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int NUM_REGS = 1 << ADDRESS_SIZE;

  // FIFO storage and control
  logic [ADDRESS_SIZE-1:0] fifo_reg_q  [DEPTH];
  logic [WORD_SIZE-1:0]    fifo_data_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Scoreboard
  logic [NUM_REGS-1:0]     pending_q, pending_d;

  // Registered write port
  logic                    regwrite_q, regwrite_d;
  logic [ADDRESS_SIZE-1:0] write_reg_q, write_reg_d;
  logic [WORD_SIZE-1:0]    write_data_q, write_data_d;

  logic                    alu_fire;
  logic                    lsu_accept;
  logic                    push;
  logic                    pop;
  logic                    issue_fire;
  logic [ADDRESS_SIZE-1:0] head_reg;
  logic [WORD_SIZE-1:0]    head_data;

  assign alu_fire   = alu_valid && (alu_reg != '0);
  assign lsu_ready  = (count_q < CNT_W'(DEPTH));
  assign lsu_accept = lsu_valid && lsu_ready;
  assign push       = lsu_accept && (lsu_reg != '0);
  // Only entries already in the FIFO at this edge can be popped, so a result
  // pushed this edge is never written before the next edge.
  assign pop        = !alu_fire && (count_q != '0);
  assign issue_fire = issue_valid && (issue_reg != '0);
  assign head_reg   = fifo_reg_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];

  // FIFO pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Scoreboard next-state: clear on pop, then set so a coincident issue wins
  always_comb begin
    pending_d = pending_q;
    if (pop)        pending_d[head_reg]  = 1'b0;
    if (issue_fire) pending_d[issue_reg] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Write-port selection: ALU first, then FIFO head, else hold data
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_fire) begin
      regwrite_d   = 1'b1;
      write_reg_d  = alu_reg;
      write_data_d = alu_data;
    end else if (pop) begin
      regwrite_d   = 1'b1;
      write_reg_d  = head_reg;
      write_data_d = head_data;
    end
  end

  // Control state with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_reg_q[wr_ptr_q]  <= lsu_reg;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  assign pending       = pending_q;
  assign query_pending = pending_q[query_reg];
  assign fifo_count    = count_q;
  assign RegWrite      = regwrite_q;
  assign WriteReg      = write_reg_q;
  assign WriteData     = write_data_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter.
module tb_reg_write_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic          clk;
  logic          rst;
  logic          alu_valid;
  logic [AW-1:0] alu_reg;
  logic [W-1:0]  alu_data;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [AW-1:0] lsu_reg;
  logic [W-1:0]  lsu_data;
  logic          issue_valid;
  logic [AW-1:0] issue_reg;
  logic [AW-1:0] query_reg;
  logic          query_pending;
  logic [31:0]   pending;
  logic [2:0]    fifo_count;
  logic          RegWrite;
  logic [AW-1:0] WriteReg;
  logic [W-1:0]  WriteData;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected drain order of LSU writes: {reg, data}
  logic [AW+W-1:0] exp_q[$];

  reg_write_arbiter #(.WORD_SIZE(W), .ADDRESS_SIZE(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_reg(lsu_reg), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .query_reg(query_reg), .query_pending(query_pending),
    .pending(pending), .fifo_count(fifo_count),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = 0; alu_data = 0;
    lsu_valid = 0; lsu_reg = 0; lsu_data = 0;
    issue_valid = 0; issue_reg = 0; query_reg = 0;
  endtask

  task automatic push_lsu(input logic [AW-1:0] r, input logic [W-1:0] d);
    lsu_valid = 1; lsu_reg = r; lsu_data = d;
    step();
    lsu_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1; alu_valid = 1; alu_reg = 3; alu_data = 32'h5; issue_valid = 1; issue_reg = 6;
    step();
    step();
    idle_inputs();
    rst = 0;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %0b expected 0", RegWrite); end
    n_checks++; if (WriteReg !== '0) begin n_fail++; $display("FAIL reset_writereg: got %0d expected 0", WriteReg); end
    n_checks++; if (WriteData !== '0) begin n_fail++; $display("FAIL reset_writedata: got %h expected 0", WriteData); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (pending !== 32'h0) begin n_fail++; $display("FAIL reset_pending: got %h expected 0", pending); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", lsu_ready); end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_reg = 5; alu_data = 32'hDEADBEEF;
    step();
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %0b expected 1", RegWrite); end
    n_checks++; if (WriteReg !== 5'd5) begin n_fail++; $display("FAIL alu_writereg: got %0d expected 5", WriteReg); end
    n_checks++; if (WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_writedata: got %h expected deadbeef", WriteData); end
    alu_reg = 0; alu_data = 32'h12345678;
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL alu_r0_regwrite: got %0b expected 0", RegWrite); end
    n_checks++; if (WriteReg !== 5'd5) begin n_fail++; $display("FAIL alu_hold_reg: got %0d expected 5", WriteReg); end
    n_checks++; if (WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_hold_data: got %h expected deadbeef", WriteData); end
    idle_inputs();
  endtask

  task automatic test_lsu_starve_drain();
    logic [AW+W-1:0] e;
    alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
    for (int i = 1; i <= 4; i++) begin
      push_lsu(AW'(i), W'(32'h11 * i));
      exp_q.push_back({AW'(i), W'(32'h11 * i)});
      n_checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd9) begin n_fail++; $display("FAIL starve_alu_write%0d: got we=%0b reg=%0d expected we=1 reg=9", i, RegWrite, WriteReg); end
    end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
    n_checks++; if (lsu_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b expected 0", lsu_ready); end
    alu_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      step();
      e = exp_q.pop_front();
      n_checks++;
      if (RegWrite !== 1'b1 || WriteReg !== e[AW+W-1:W] || WriteData !== e[W-1:0]) begin
        n_fail++;
        $display("FAIL drain%0d: got we=%0b reg=%0d data=%h expected we=1 reg=%0d data=%h", i, RegWrite, WriteReg, WriteData, e[AW+W-1:W], e[W-1:0]);
      end
      n_checks++; if (fifo_count !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_count%0d: got %0d expected %0d", i, fifo_count, 4 - i); end
    end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL drained_ready: got %0b expected 1", lsu_ready); end
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL drained_idle: got %0b expected 0", RegWrite); end
    // No bypass: a push into an empty FIFO is written one edge later
    push_lsu(5'd6, 32'h66);
    n_checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd1) begin n_fail++; $display("FAIL no_bypass: got we=%0b count=%0d expected we=0 count=1", RegWrite, fifo_count); end
    step();
    n_checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd6 || WriteData !== 32'h66) begin n_fail++; $display("FAIL bypass_pop: got we=%0b reg=%0d data=%h expected we=1 reg=6 data=66", RegWrite, WriteReg, WriteData); end
    idle_inputs();
  endtask

  task automatic test_pending();
    issue_valid = 1; issue_reg = 7;
    step();
    issue_valid = 0; query_reg = 7;
    #1;
    n_checks++; if (query_pending !== 1'b1) begin n_fail++; $display("FAIL pend_query_set: got %0b expected 1", query_pending); end
    n_checks++; if (pending !== 32'h80) begin n_fail++; $display("FAIL pend_vec_set: got %h expected 00000080", pending); end
    push_lsu(5'd7, 32'h77);
    n_checks++; if (pending[7] !== 1'b1) begin n_fail++; $display("FAIL pend_held_while_queued: got %0b expected 1", pending[7]); end
    step();
    n_checks++; if (RegWrite !== 1'b1 || WriteReg !== 5'd7) begin n_fail++; $display("FAIL pend_pop_write: got we=%0b reg=%0d expected we=1 reg=7", RegWrite, WriteReg); end
    n_checks++; if (query_pending !== 1'b0 || pending !== 32'h0) begin n_fail++; $display("FAIL pend_cleared: got q=%0b vec=%h expected q=0 vec=0", query_pending, pending); end
    idle_inputs();
  endtask

  task automatic test_set_priority_and_pushpop();
    logic [AW-1:0] regs [4];
    regs[0] = 3; regs[1] = 10; regs[2] = 11; regs[3] = 12;
    issue_valid = 1; issue_reg = 3;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
    for (int i = 0; i < 4; i++) push_lsu(regs[i], W'(32'h100 + i));
    n_checks++; if (fifo_count !== 3'd4 || pending[3] !== 1'b1) begin n_fail++; $display("FAIL prio_setup: got count=%0d p3=%0b expected count=4 p3=1", fifo_count, pending[3]); end
    alu_valid = 0; issue_valid = 1; issue_reg = 3;
    step();
    issue_valid = 0;
    n_checks++; if (WriteReg !== 5'd3 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL prio_pop3: got we=%0b reg=%0d expected we=1 reg=3", RegWrite, WriteReg); end
    n_checks++; if (pending[3] !== 1'b1) begin n_fail++; $display("FAIL prio_set_wins: got %0b expected 1", pending[3]); end
    step();
    n_checks++; if (fifo_count !== 3'd2 || WriteReg !== 5'd10) begin n_fail++; $display("FAIL prio_pop10: got count=%0d reg=%0d expected count=2 reg=10", fifo_count, WriteReg); end
    push_lsu(5'd13, 32'h113);
    n_checks++; if (fifo_count !== 3'd2 || WriteReg !== 5'd11 || WriteData !== 32'h102) begin n_fail++; $display("FAIL pushpop: got count=%0d reg=%0d data=%h expected count=2 reg=11 data=102", fifo_count, WriteReg, WriteData); end
    step();
    n_checks++; if (WriteReg !== 5'd12 || WriteData !== 32'h103) begin n_fail++; $display("FAIL order12: got reg=%0d data=%h expected reg=12 data=103", WriteReg, WriteData); end
    step();
    n_checks++; if (WriteReg !== 5'd13 || WriteData !== 32'h113 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL order13: got reg=%0d data=%h count=%0d expected reg=13 data=113 count=0", WriteReg, WriteData, fifo_count); end
    n_checks++; if (pending !== 32'h8) begin n_fail++; $display("FAIL prio_final_pending: got %h expected 00000008", pending); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1; issue_reg = 2;
    alu_valid = 1; alu_reg = 9; alu_data = 32'h99;
    step();
    issue_valid = 0;
    for (int i = 1; i <= 3; i++) push_lsu(AW'(i), W'(32'h200 + i));
    n_checks++; if (fifo_count !== 3'd3 || pending[2] !== 1'b1 || RegWrite !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got count=%0d p2=%0b we=%0b expected count=3 p2=1 we=1", fifo_count, pending[2], RegWrite); end
    rst = 1; lsu_valid = 1; lsu_reg = 4; lsu_data = 32'h44; issue_valid = 1; issue_reg = 4;
    step();
    rst = 0;
    idle_inputs();
    n_checks++; if (fifo_count !== 3'd0 || pending !== 32'h0) begin n_fail++; $display("FAIL midrst_state: got count=%0d pending=%h expected count=0 pending=0", fifo_count, pending); end
    n_checks++; if (RegWrite !== 1'b0 || WriteReg !== '0 || WriteData !== '0) begin n_fail++; $display("FAIL midrst_port: got we=%0b reg=%0d data=%h expected all 0", RegWrite, WriteReg, WriteData); end
    n_checks++; if (lsu_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %0b expected 1", lsu_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write%0d: got %0b expected 0", i, RegWrite); end
    end
  endtask

  task automatic test_zero_reg();
    issue_valid = 1; issue_reg = 5;
    step();
    issue_reg = 0; lsu_valid = 1; lsu_reg = 0; lsu_data = 32'hABCD;
    step();
    idle_inputs();
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL zero_push_count: got %0d expected 0", fifo_count); end
    n_checks++; if (pending !== 32'h20) begin n_fail++; $display("FAIL zero_issue_pending: got %h expected 00000020", pending); end
    step();
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL zero_no_write: got %0b expected 0", RegWrite); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_alu();
    test_lsu_starve_drain();
    test_pending();
    test_set_priority_and_pushpop();
    test_reset_mid();
    test_zero_reg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
